// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: NREQ requesters share one fixed-latency single-port memory, round-robin (or fixed priority with DMEM_ARB_FIXED_PRIO_EN).
// Latency: gnt and mem_en one edge after req; rvalid MEM_LAT+1 cycles after gnt; next grant no earlier than MEM_LAT+2 cycles after the previous one.
// Backpressure: one access in flight; requests held while busy are arbitrated on return to IDLE, requests dropped before gnt are ignored.
module dmem_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*DW-1:0]   wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     win_idx;
    logic              win_vld;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Winner select: lowest requesting port index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_vld = 1'b1;
                win_idx = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW:0]       cand;

    // Winner select: first requesting port at or above rr_ptr, wrapping past NREQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!win_vld && req_i[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    // Pointer moves past the port whose access just completed.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_WAIT && cnt_q == '0) begin
            rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    // Round-robin pointer register; cleared by reset so an abandoned access leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, one ISSUE cycle, then WAIT until the latency counter expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values: pulses default low, memory command and read data hold between accesses.
    always_comb begin
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d       = NREQ'(1) << win_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_i[win_idx];
                    mem_addr_d  = addr_i[win_idx*AW +: AW];
                    mem_wdata_d = wdata_i[win_idx*DW +: DW];
                    owner_d     = win_idx;
                    cnt_d       = CW'(MEM_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rvalid_d = NREQ'(1) << owner_q;
                    // A write completes without disturbing the last read result.
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and access bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus stream.
// A cycle-count reference model predicts every output; directed phases pin literal values.
// Each instance drives its own small behavioural memory.
module tb_dmem_port_arbiter;

    localparam int N    = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    req, we;
    logic [9:0]    addr;
    logic [63:0]   wdata;

    logic [1:0]    gnt [2];
    logic [1:0]    rvalid [2];
    logic [31:0]   rdata [2];
    logic          busy [2];
    logic          mem_en [2];
    logic          mem_we [2];
    logic [4:0]    mem_addr [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   srd [2];
    logic [31:0]   smem [2][32];

    int n_chk, n_err;
    bit cmp_en;

    dmem_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT0)) u_dut0 (
        .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .busy_o(busy[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(srd[0]));

    dmem_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .busy_o(busy[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(srd[1]));

    // Memory stubs: word i starts as i; read data is captured on the strobe and then held.
    initial begin
        for (int d = 0; d < 2; d++) begin
            srd[d] <= 32'd0;
            for (int i = 0; i < 32; i++) smem[d][i] <= 32'(i);
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d]) begin
                srd[d] <= smem[d][mem_addr[d]];
                if (mem_we[d]) smem[d][mem_addr[d]] <= mem_wdata[d];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [1:0]    e_gnt [2];
    logic [1:0]    e_rvalid [2];
    logic [31:0]   e_rdata [2];
    logic          e_busy [2];
    logic          e_en [2];
    logic          e_we [2];
    logic [4:0]    e_addr [2];
    logic [31:0]   e_wdata [2];
    int            act [2], age [2], own [2], ptr [2];
    logic          pend_rd [2];
    logic [31:0]   pend_val [2];
    logic [31:0]   mmem [2][32];

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) mmem[d][i] = 32'(i);
    end

    function automatic int pick(input logic [1:0] r, input int p);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
        return 0;
    endfunction

    // One access at a time: granted at age 0, memory touched at age 1, done at age lat+1.
    task automatic model_step(input int d);
        int lat;
        bit was_free;
        int w;
        lat = (d == 0) ? LAT0 : LAT1;
        e_gnt[d]    = 2'b00;
        e_rvalid[d] = 2'b00;
        e_en[d]     = 1'b0;
        was_free    = (act[d] == 0);
        if (act[d] != 0) begin
            age[d]++;
            if (age[d] == 1) begin
                if (pend_rd[d]) pend_val[d] = mmem[d][e_addr[d]];
                else            mmem[d][e_addr[d]] = e_wdata[d];
            end
            if (age[d] == lat + 1) begin
                e_rvalid[d] = 2'(1 << own[d]);
                if (pend_rd[d]) e_rdata[d] = pend_val[d];
                ptr[d] = (own[d] + 1) % N;
                act[d] = 0;
            end
        end
        if (was_free && req != 2'b00) begin
            w = pick(req, ptr[d]);
            e_gnt[d]   = 2'(1 << w);
            e_en[d]    = 1'b1;
            e_we[d]    = we[w];
            e_addr[d]  = addr[w*AW +: AW];
            e_wdata[d] = wdata[w*DW +: DW];
            pend_rd[d] = !we[w];
            own[d]     = w;
            act[d]     = 1;
            age[d]     = 0;
        end
        e_busy[d] = (act[d] != 0);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                act[d] = 0; age[d] = 0; own[d] = 0; ptr[d] = 0; pend_rd[d] = 1'b0;
                e_gnt[d] = 2'b00; e_rvalid[d] = 2'b00; e_rdata[d] = 32'd0; e_busy[d] = 1'b0;
                e_en[d] = 1'b0; e_we[d] = 1'b0; e_addr[d] = 5'd0; e_wdata[d] = 32'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] actv, input logic [31:0] expv);
        n_chk++;
        if (actv !== expv) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, d, actv, expv, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("m_gnt", d, 32'(gnt[d]), 32'(e_gnt[d]));
                chk("m_rvalid", d, 32'(rvalid[d]), 32'(e_rvalid[d]));
                chk("m_busy", d, 32'(busy[d]), 32'(e_busy[d]));
                chk("m_mem_en", d, 32'(mem_en[d]), 32'(e_en[d]));
                chk("m_mem_we", d, 32'(mem_we[d]), 32'(e_we[d]));
                chk("m_mem_addr", d, 32'(mem_addr[d]), 32'(e_addr[d]));
                chk("m_mem_wdata", d, mem_wdata[d], e_wdata[d]);
                if (e_rvalid[d] != 2'b00 && pend_rd[d]) chk("m_rdata", d, rdata[d], e_rdata[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy[0] || busy[1]) && t < 50) begin
            tick();
            t++;
        end
        chk("drain_timeout", 0, 32'(busy[0] | busy[1]), 0);
        tick();
    endtask

    task automatic chk_all_zero(input int d);
        chk("rst_gnt", d, 32'(gnt[d]), 0);
        chk("rst_rvalid", d, 32'(rvalid[d]), 0);
        chk("rst_rdata", d, rdata[d], 0);
        chk("rst_busy", d, 32'(busy[d]), 0);
        chk("rst_mem_en", d, 32'(mem_en[d]), 0);
        chk("rst_mem_we", d, 32'(mem_we[d]), 0);
        chk("rst_mem_addr", d, 32'(mem_addr[d]), 0);
        chk("rst_mem_wdata", d, mem_wdata[d], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        int t;
        int cnt_g0 [2];
        int cnt_en [2];
        n_chk = 0;
        n_err = 0;
        cmp_en = 1'b0;
        reset = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) chk_all_zero(d);
        reset = 1'b0;
        tick();

        // Read of port 0, address 5.
        drive(2'b01, 2'b00, 5, 0, 0, 0);
        tick();
        chk("t1_gnt", 0, 32'(gnt[0]), 1);
        chk("t1_mem_en", 0, 32'(mem_en[0]), 1);
        chk("t1_mem_addr", 0, 32'(mem_addr[0]), 5);
        chk("t1_busy", 0, 32'(busy[0]), 1);
        drive(2'b00, 2'b00, 5, 0, 0, 0);
        tick();
        chk("t1_gnt_clear", 0, 32'(gnt[0]), 0);
        chk("t1_mem_en_clear", 0, 32'(mem_en[0]), 0);
        tick();
        chk("t1_rvalid", 0, 32'(rvalid[0]), 1);
        chk("t1_rdata", 0, rdata[0], 5);
        tick();
        chk("t1_rvalid_clear", 0, 32'(rvalid[0]), 0);
        tick();
        chk("t1_rvalid_lat3", 1, 32'(rvalid[1]), 1);
        chk("t1_rdata_lat3", 1, rdata[1], 5);
        drain();

        // Write from port 1: address 7, data 99.
        drive(2'b10, 2'b10, 0, 7, 0, 99);
        tick();
        chk("t2_gnt", 0, 32'(gnt[0]), 2);
        chk("t2_mem_en", 0, 32'(mem_en[0]), 1);
        chk("t2_mem_we", 0, 32'(mem_we[0]), 1);
        chk("t2_mem_addr", 0, 32'(mem_addr[0]), 7);
        chk("t2_mem_wdata", 0, mem_wdata[0], 99);
        drive(2'b00, 2'b00, 0, 7, 0, 99);
        tick();
        chk("t2_mem_en_clear", 0, 32'(mem_en[0]), 0);
        tick();
        chk("t2_rvalid", 0, 32'(rvalid[0]), 2);
        drain();

        // Both ports held for four grants.
        drive(2'b11, 2'b00, 3, 9, 0, 0);
        t = 0;
        while (got.size() < 4 && t < 40) begin
            tick();
            t++;
            if (gnt[0] != 2'b00) got.push_back(gnt[0][1] ? 1 : 0);
        end
        drive(2'b00, 2'b00, 3, 9, 0, 0);
        chk("t3_grant_count", 0, 32'(got.size()), 4);
        foreach (got[i]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            chk("t3_grant_order", i, 32'(got[i]), 0);
`else
            chk("t3_grant_order", i, 32'(got[i]), 32'(i % 2));
`endif
        end
        drain();

        // Latency 3 instance: port 1 arrives while busy with port 0.
        drive(2'b01, 2'b00, 2, 4, 0, 0);
        tick();
        chk("t4_gnt0", 1, 32'(gnt[1]), 1);
        drive(2'b10, 2'b00, 2, 4, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t4_busy", 1, 32'(busy[1]), 1);
        end
        tick();
        chk("t4_rvalid", 1, 32'(rvalid[1]), 1);
        chk("t4_rdata", 1, rdata[1], 2);
        tick();
        chk("t4_gnt1", 1, 32'(gnt[1]), 2);
        drive(2'b00, 2'b00, 2, 4, 0, 0);
        drain();

        // Reset in WAIT: set rr_ptr to 1 first, then abandon a port-1 access.
        drive(2'b01, 2'b00, 1, 6, 0, 0);
        tick();
        drive(2'b00, 2'b00, 1, 6, 0, 0);
        drain();
        drive(2'b10, 2'b00, 1, 6, 0, 0);
        tick();
        chk("t5_gnt", 1, 32'(gnt[1]), 2);
        drive(2'b00, 2'b00, 1, 6, 0, 0);
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk_all_zero(d);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            tick();
            chk("t5_no_rvalid", 1, 32'(rvalid[1]), 0);
        end
        drive(2'b11, 2'b00, 1, 6, 0, 0);
        tick();
        chk("t5_regrant", 0, 32'(gnt[0]), 1);
        chk("t5_regrant", 1, 32'(gnt[1]), 1);
        drive(2'b00, 2'b00, 1, 6, 0, 0);
        drain();

        // Port 0 pulses while port 1 is being served.
        drive(2'b10, 2'b00, 0, 8, 0, 0);
        tick();
        drive(2'b01, 2'b00, 0, 8, 0, 0);
        tick();
        drive(2'b00, 2'b00, 0, 8, 0, 0);
        for (int d = 0; d < 2; d++) begin
            cnt_g0[d] = 0;
            cnt_en[d] = 0;
        end
        repeat (8) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (gnt[d][0]) cnt_g0[d]++;
                if (mem_en[d]) cnt_en[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("t6_no_gnt0", d, 32'(cnt_g0[d]), 0);
            chk("t6_no_mem_en", d, 32'(cnt_en[d]), 0);
        end

        // Random traffic with occasional asynchronous resets.
        repeat (4000) begin
            tick();
            req   = {1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4)};
            we    = 2'($urandom_range(0, 3));
            addr  = 10'($urandom_range(0, 1023));
            wdata = {$urandom, $urandom};
            reset = ($urandom_range(0, 399) == 0);
        end
        tick();
        reset = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
